float_to_fixed_conv: RTL and testbench

- Converts one IEEE-754 single-precision operand into a signed WIDTH-bit two's-complement fixed-point value with FRAC_BITS fraction bits.
- Uses an iterative one-bit-per-cycle alignment shifter behind valid/ready handshakes on both sides.
- Sits after the floating-point datapath (adder/multiplier/normaliser). It is the inverse of mantissa normalisation: the implicit-1 mantissa is de-normalised back onto a fixed binary point, which feeds the integer argmax/classification stage.

---
 rtl/float_to_fixed_conv.sv | 215 +++++++++++++++++++++
 tb/tb_float_to_fixed_conv.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_to_fixed_conv.sv
// float_to_fixed_conv
// -------------------
// Converts one IEEE-754 single-precision operand into a signed WIDTH-bit
// two's-complement fixed-point value with FRAC_BITS fraction bits. The
// implicit-1 mantissa is de-normalised onto the fixed binary point by an
// iterative shifter that moves one bit per cycle.
//
// Optional feature macro: F2X_ROUND_EN
//   defined   : round to nearest, ties away from zero (on magnitude)
//   undefined : truncate toward zero (same latency)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand valid
//   in_ready   converter can accept (high only in IDLE)
//   in_data    IEEE-754 single {sign, exp[7:0], man[22:0]}
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts result
//   out_data   signed fixed-point result
//   out_ovf    result saturated (overflow or +/-Inf)
//   out_inv    input was NaN
//   dbg_state  current FSM state (IDLE=0, SHIFT=1, FIX=2, DONE=3)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and data stable until that edge;
// ready may be asserted independently of valid.

module float_to_fixed_conv #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_inv,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIX   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One spare bit above WIDTH so a rounding carry is still visible to the
    // magnitude limit check.
    localparam int MAG_W = WIDTH + 1;

    localparam logic [WIDTH-1:0]       POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]       NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [MAG_W-1:0]       POS_LIM = MAG_W'(POS_MAX);
    localparam logic [MAG_W-1:0]       NEG_LIM = MAG_W'(NEG_MIN);
    localparam logic signed [9:0]      EF_SAT  = 10'(WIDTH - 1);
    localparam logic signed [9:0]      FRAC_S  = 10'(FRAC_BITS);

    // Operand decode (only meaningful while accepting)
    logic              in_sign;
    logic [7:0]        in_exp;
    logic [22:0]       in_man;
    logic signed [9:0] in_e;
    logic signed [9:0] in_ef;   // e + FRAC_BITS: bit position of the leading 1
    logic signed [9:0] in_sh;   // net shift to apply to {1, man}
    logic [9:0]        in_cnt;

    assign in_sign = in_data[31];
    assign in_exp  = in_data[30:23];
    assign in_man  = in_data[22:0];
    assign in_e    = $signed({2'b00, in_exp}) - 10'sd127;
    assign in_ef   = in_e + FRAC_S;
    assign in_sh   = in_ef - 10'sd23;
    assign in_cnt  = in_sh[9] ? 10'(-in_sh) : 10'(in_sh);

    // State and datapath registers
    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic              left_q, left_d;
    logic              guard_q, guard_d;
    logic [9:0]        cnt_q, cnt_d;
    logic [MAG_W-1:0]  mag_q, mag_d;
    logic [WIDTH-1:0]  data_d;
    logic              ovf_d, inv_d;

    // Rounding increment applied in FIX
    logic              round_inc;
    logic [MAG_W-1:0]  mag_rnd;

`ifdef F2X_ROUND_EN
    assign round_inc = guard_q;
`else
    // The guard bit is still tracked but discarded: truncation toward zero.
    assign round_inc = guard_q & 1'b0;
`endif

    assign mag_rnd = mag_q + MAG_W'(round_inc);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        left_d  = left_q;
        guard_d = guard_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        data_d  = out_data;
        ovf_d   = out_ovf;
        inv_d   = out_inv;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    left_d  = ~in_sh[9];
                    guard_d = 1'b0;
                    cnt_d   = in_cnt;
                    mag_d   = MAG_W'({1'b1, in_man});
                    ovf_d   = 1'b0;
                    inv_d   = 1'b0;
                    state_d = DONE;
                    if (in_exp == 8'hFF) begin
                        if (in_man != 23'd0) begin
                            data_d = '0;
                            inv_d  = 1'b1;
                        end else begin
                            data_d = in_sign ? NEG_MIN : POS_MAX;
                            ovf_d  = 1'b1;
                        end
                    end else if (in_exp == 8'h00) begin
                        // Zero and denormals flush to zero
                        data_d = '0;
                    end else if (in_ef >= EF_SAT) begin
                        // -2^(WIDTH-1) itself is representable
                        if (in_sign && (in_man == 23'd0) && (in_ef == EF_SAT)) begin
                            data_d = NEG_MIN;
                        end else begin
                            data_d = in_sign ? NEG_MIN : POS_MAX;
                            ovf_d  = 1'b1;
                        end
                    end else if (in_ef < -10'sd1) begin
                        // Magnitude below one half rounds to zero either way
                        data_d = '0;
                    end else begin
                        state_d = (in_cnt != 10'd0) ? SHIFT : FIX;
                    end
                end
            end

            SHIFT: begin
                if (left_q) begin
                    mag_d = {mag_q[MAG_W-2:0], 1'b0};
                end else begin
                    guard_d = mag_q[0];
                    mag_d   = {1'b0, mag_q[MAG_W-1:1]};
                end
                cnt_d = cnt_q - 10'd1;
                if (cnt_q == 10'd1) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                if ((!sign_q && (mag_rnd > POS_LIM)) || (sign_q && (mag_rnd > NEG_LIM))) begin
                    data_d = sign_q ? NEG_MIN : POS_MAX;
                    ovf_d  = 1'b1;
                end else begin
                    data_d = sign_q ? -mag_rnd[WIDTH-1:0] : mag_rnd[WIDTH-1:0];
                end
                state_d = DONE;
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            left_q   <= 1'b0;
            guard_q  <= 1'b0;
            cnt_q    <= '0;
            mag_q    <= '0;
            out_data <= '0;
            out_ovf  <= 1'b0;
            out_inv  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            left_q   <= left_d;
            guard_q  <= guard_d;
            cnt_q    <= cnt_d;
            mag_q    <= mag_d;
            out_data <= data_d;
            out_ovf  <= ovf_d;
            out_inv  <= inv_d;
        end
    end

endmodule

// File: tb/tb_float_to_fixed_conv.sv
// Bench for float_to_fixed_conv (WIDTH=32, FRAC_BITS=16): directed cases
// pinned to hand-computed values, then randomized operands compared against
// an arithmetic reference model.

module tb_float_to_fixed_conv;

    localparam int WIDTH = 32;
    localparam int FRAC  = 16;

    localparam logic [WIDTH-1:0] POS_MAX = 32'h7FFF_FFFF;
    localparam logic [WIDTH-1:0] NEG_MIN = 32'h8000_0000;
    localparam longint LIM_POS = (longint'(1) <<< (WIDTH - 1)) - 1;
    localparam longint LIM_NEG = longint'(1) <<< (WIDTH - 1);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             ovf;
        logic             inv;
        int               lat;
    } res_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;
    logic             out_inv;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // {inv, ovf, data} of results still owed by the DUT
    logic [WIDTH+1:0] exp_q[$];

    float_to_fixed_conv #(.WIDTH(WIDTH), .FRAC_BITS(FRAC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_inv   (out_inv),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // Value = (-1)^s * {1,man} * 2^(e - 23), scaled by 2^FRAC, computed
    // directly with wide integer arithmetic.
    function automatic res_t model(input logic [31:0] f);
        res_t   r;
        longint m;
        longint q;
        int     e_f;
        int     sh;
        logic   s;
        r.data = '0;
        r.ovf  = 1'b0;
        r.inv  = 1'b0;
        r.lat  = 1;
        s      = f[31];
        if (f[30:23] == 8'hFF) begin
            if (f[22:0] != 23'd0) begin
                r.inv = 1'b1;
            end else begin
                r.ovf  = 1'b1;
                r.data = s ? NEG_MIN : POS_MAX;
            end
        end else if (f[30:23] != 8'h00) begin
            e_f = int'(f[30:23]) - 127 + FRAC;
            if (e_f >= WIDTH - 1) begin
                if (s && f[22:0] == 23'd0 && e_f == WIDTH - 1) begin
                    r.data = NEG_MIN;
                end else begin
                    r.ovf  = 1'b1;
                    r.data = s ? NEG_MIN : POS_MAX;
                end
            end else if (e_f >= -1) begin
                sh    = e_f - 23;
                r.lat = (sh < 0 ? -sh : sh) + 2;
                m     = longint'({1'b1, f[22:0]});
                if (sh >= 0) begin
                    q = m <<< sh;
                end else begin
                    q = m >>> (-sh);
`ifdef F2X_ROUND_EN
                    q = q + ((m >>> (-sh - 1)) & 64'sd1);
`endif
                end
                if ((!s && q > LIM_POS) || (s && q > LIM_NEG)) begin
                    r.ovf  = 1'b1;
                    r.data = s ? NEG_MIN : POS_MAX;
                end else begin
                    r.data = s ? WIDTH'(-q) : WIDTH'(q);
                end
            end
        end
        return r;
    endfunction

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    // Every cycle out_valid is high the presented result must match the
    // oldest owed result; it leaves the queue on the output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_unexpected: got result %0h with none owed", out_data);
            end else begin
                check("out_result", 64'({out_inv, out_ovf, out_data}), 64'(exp_q[0]));
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
    end

    // ---------------- driver ----------------
    task automatic run_op(input logic [31:0] d, input int hold, input bit poke);
        res_t r;
        int   lat;
        int   wait_n;
        r = model(d);
        @(negedge clk);
        wait_n = 0;
        while (!in_ready && wait_n < 60) begin
            @(negedge clk);
            wait_n++;
        end
        check("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        exp_q.push_back({r.inv, r.ovf, r.data});
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid) check("busy_ready", 64'(in_ready), 64'd0);
        end while (!out_valid && lat < 40);
        check("latency", 64'(lat), 64'(r.lat));
        for (int i = 0; i < hold; i++) begin
            check("hold_ready", 64'(in_ready), 64'd0);
            if (poke) begin
                in_valid = 1'b1;
                in_data  = $urandom;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("ready_after_hs", 64'(in_ready), 64'd1);
        check("valid_after_hs", 64'(out_valid), 64'd0);
    endtask

    task automatic pin(input string name, input logic [31:0] d, input logic [WIDTH-1:0] data,
                       input logic ovf, input logic inv, input int lat);
        res_t r;
        r = model(d);
        check({name, "_data"}, 64'(r.data), 64'(data));
        check({name, "_flags"}, 64'({r.ovf, r.inv}), 64'({ovf, inv}));
        check({name, "_lat"}, 64'(r.lat), 64'(lat));
    endtask

    function automatic logic [31:0] rand_float();
        logic [31:0] f;
        int          cat;
        f[31]    = 1'($urandom_range(0, 1));
        f[22:0]  = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
        cat      = $urandom_range(0, 9);
        if (cat == 0)      f[30:23] = 8'hFF;
        else if (cat == 1) f[30:23] = 8'h00;
        else if (cat == 2) f[30:23] = 8'($urandom_range(140, 150));
        else               f[30:23] = 8'($urandom_range(102, 142));
        return f;
    endfunction

    // ---------------- main sequence ----------------
    logic [WIDTH-1:0] tie_exp;
    logic [WIDTH-1:0] half_exp;

    initial begin
`ifdef F2X_ROUND_EN
        tie_exp  = 32'h0000_0002;
        half_exp = 32'h0000_0001;
`else
        tie_exp  = 32'h0000_0001;
        half_exp = 32'h0000_0000;
`endif
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_flags", 64'({out_ovf, out_inv}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // Hand-computed expectations that pin the reference model
        pin("pin_one",   32'h3F80_0000, 32'h0001_0000, 1'b0, 1'b0, 9);
        pin("pin_neg",   32'hC020_0000, 32'hFFFD_8000, 1'b0, 1'b0, 8);
        pin("pin_tie",   32'h37C0_0000, tie_exp,       1'b0, 1'b0, 25);
        pin("pin_inf",   32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
        pin("pin_nan",   32'h7FC0_0000, 32'h0000_0000, 1'b0, 1'b1, 1);
        pin("pin_nmin",  32'hC700_0000, 32'h8000_0000, 1'b0, 1'b0, 1);
        pin("pin_psat",  32'h4700_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
        pin("pin_half",  32'h3700_0000, half_exp,      1'b0, 1'b0, 26);
        pin("pin_small", 32'h36FF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1);

        // Directed operands through the DUT
        run_op(32'h3F80_0000, 0, 1'b0);
        run_op(32'hC020_0000, 0, 1'b0);
        run_op(32'h37C0_0000, 0, 1'b0);
        run_op(32'h7F80_0000, 0, 1'b0);
        run_op(32'hFF80_0000, 0, 1'b0);
        run_op(32'h7FC0_0000, 0, 1'b0);
        run_op(32'hC700_0000, 0, 1'b0);
        run_op(32'h4700_0000, 0, 1'b0);
        run_op(32'h0000_0000, 0, 1'b0);
        run_op(32'h8000_0001, 0, 1'b0);
        run_op(32'h3700_0000, 0, 1'b0);
        run_op(32'h36FF_FFFF, 0, 1'b0);
        run_op(32'h46FF_FFFF, 0, 1'b0);
        run_op(32'hC6FF_FFFF, 0, 1'b0);

        // Backpressure: result held 5 cycles while new operands are offered
        run_op(32'h3F80_0000, 5, 1'b1);

        // Reset during SHIFT discards the pending result
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h3F80_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("midrst_valid", 64'(out_valid), 64'd0);
            check("midrst_data", 64'(out_data), 64'd0);
            check("midrst_ready", 64'(in_ready), 64'd1);
        end
        rst_n = 1'b1;
        run_op(32'h4000_0000, 0, 1'b0);

        // Randomized operands
        for (int n = 0; n < 250; n++) begin
            run_op(rand_float(), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Bound on total run time
    initial begin
        #900000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
